// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a 4x8 register file.
// Each accepted access runs IDLE (sample) -> ACCESS -> RESP.
module regfile_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [1:0] addr0,
  input  logic [1:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic [1:0] rf_addr,
  output logic       rf_rd,
  output logic       rf_wr,
  output logic [7:0] rf_wdata,
  input  logic [7:0] rf_rdata,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_ptr;
  logic       r_win;
  logic       r_we;
  logic [1:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata [2];

  logic       w_any;
  logic       w_pick;
  logic       w_in_access;
  logic       w_in_resp;
  logic [1:0] w_gnt;
  logic [1:0] w_done;

  assign w_any = req0 | req1;

  // The pointer only matters on a tie; a lone requester always wins.
  always_comb begin
    w_pick = 1'b0;
    if (req0 && req1) begin
      w_pick = r_ptr;
    end else begin
      w_pick = req1;
    end
  end

  // Gating with rst kills the strobes in the reset cycle itself, so an
  // access interrupted by reset never reaches the register file.
  assign w_in_access = (r_state == ACCESS) && !rst;
  assign w_in_resp   = (r_state == RESP) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 2'd0;
      r_wdata <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_win   <= w_pick;
            r_ptr   <= ~w_pick;
            r_we    <= w_pick ? we1 : we0;
            r_addr  <= w_pick ? addr1 : addr0;
            r_wdata <= w_pick ? wdata1 : wdata0;
            r_state <= ACCESS;
          end
        end
        ACCESS:  r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign w_gnt[gi]  = w_in_access && (r_win == 1'(gi));
      assign w_done[gi] = w_in_resp && (r_win == 1'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rdata[gi] <= 8'h00;
        end else if (w_gnt[gi] && !r_we) begin
          r_rdata[gi] <= rf_rdata;
        end
      end
    end
  endgenerate

  assign gnt0     = w_gnt[0];
  assign gnt1     = w_gnt[1];
  assign done0    = w_done[0];
  assign done1    = w_done[1];
  assign rdata0   = r_rdata[0];
  assign rdata1   = r_rdata[1];
  assign rf_addr  = w_in_access ? r_addr : 2'd0;
  assign rf_rd    = w_in_access && !r_we;
  assign rf_wr    = w_in_access && r_we;
  assign rf_wdata = (w_in_access && r_we) ? r_wdata : 8'h00;
  assign busy     = (r_state != IDLE) && !rst;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-schedule model of the arbiter.
module tb_regfile_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] rdata0, rdata1;
  logic [1:0] rf_addr;
  logic       rf_rd, rf_wr;
  logic [7:0] rf_wdata, rf_rdata;
  logic       busy;

  regfile_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .rf_addr(rf_addr), .rf_rd(rf_rd), .rf_wr(rf_wr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // External register file seen by the arbiter
  logic [7:0] rf_mem [4];
  initial for (int i = 0; i < 4; i++) rf_mem[i] = 8'h00;
  always @(posedge clk) if (rf_wr) rf_mem[rf_addr] <= rf_wdata;
  assign rf_rdata = rf_rd ? rf_mem[rf_addr] : 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Requester-side stimulus state
  bit         pend [2];
  bit         p_we [2];
  logic [1:0] p_addr [2];
  logic [7:0] p_wdata [2];
  bit         rand_en = 0;
  bit         auto_repost = 0;

  // Reference model: schedule of the one outstanding access
  int         cyc = 0;
  bit         acc_valid = 0;
  int         acc_t = 0;
  bit         acc_w, acc_we;
  logic [1:0] acc_addr;
  logic [7:0] acc_wdata;
  int         next_sample = 0;
  bit         ptr = 0;
  logic [7:0] ref_mem [4];
  logic [7:0] exp_rd [2];

  int g_cyc [$];
  int g_id  [$];

  task automatic model_step();
    bit in_acc, in_resp, w;
    in_acc  = !rst && acc_valid && (cyc == acc_t);
    in_resp = !rst && acc_valid && (cyc == acc_t + 1);
    check_eq("gnt0",  gnt0,  in_acc && !acc_w);
    check_eq("gnt1",  gnt1,  in_acc && acc_w);
    check_eq("done0", done0, in_resp && !acc_w);
    check_eq("done1", done1, in_resp && acc_w);
    check_eq("busy",  busy,  in_acc || in_resp);
    check_eq("rf_rd", rf_rd, in_acc && !acc_we);
    check_eq("rf_wr", rf_wr, in_acc && acc_we);
    check_eq("rf_addr", rf_addr, in_acc ? acc_addr : 2'd0);
    check_eq("rf_wdata", rf_wdata, (in_acc && acc_we) ? acc_wdata : 8'h00);
    check_eq("rdata0", rdata0, exp_rd[0]);
    check_eq("rdata1", rdata1, exp_rd[1]);
    if (gnt0 === 1'b1) begin g_cyc.push_back(cyc); g_id.push_back(0); end
    if (gnt1 === 1'b1) begin g_cyc.push_back(cyc); g_id.push_back(1); end

    if (rst) begin
      acc_valid   = 0;
      ptr         = 0;
      exp_rd[0]   = 8'h00;
      exp_rd[1]   = 8'h00;
      next_sample = cyc + 1;
    end else begin
      if (in_acc) begin
        $display("txn cyc=%0d req%0d %s addr=%0d data=%02h", cyc, acc_w,
                 acc_we ? "WR" : "RD", acc_addr, acc_we ? acc_wdata : ref_mem[acc_addr]);
        if (acc_we) ref_mem[acc_addr] = acc_wdata;
        else exp_rd[acc_w] = ref_mem[acc_addr];
        if (!auto_repost) pend[acc_w] = 0;
      end
      if (in_resp) acc_valid = 0;
      if (cyc >= next_sample && (req0 || req1)) begin
        w = (req0 && req1) ? ptr : req1;
        acc_w       = w;
        acc_we      = p_we[w];
        acc_addr    = p_addr[w];
        acc_wdata   = p_wdata[w];
        acc_t       = cyc + 1;
        acc_valid   = 1;
        next_sample = cyc + 3;
        ptr         = !w;
      end
    end
  endtask

  task automatic drive_cycle(input logic r);
    @(posedge clk);
    cyc++;
    #1;
    rst = r;
    if (rand_en) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]    = 1;
          p_we[i]    = 1'($urandom_range(0, 1));
          p_addr[i]  = 2'($urandom_range(0, 3));
          p_wdata[i] = 8'($urandom_range(0, 255));
        end
      end
    end
    req0 = pend[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
    req1 = pend[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];
    #1;
    model_step();
  endtask

  task automatic post(input int i, input bit we, input logic [1:0] a, input logic [7:0] d);
    pend[i] = 1; p_we[i] = we; p_addr[i] = a; p_wdata[i] = d;
  endtask

  task automatic do_txn(input int i, input bit we, input logic [1:0] a, input logic [7:0] d);
    int k;
    post(i, we, a, d);
    k = 0;
    while (k < 20 && (pend[i] || acc_valid)) begin
      drive_cycle(1'b0);
      k++;
    end
    check_eq("txn_timeout", k < 20, 1);
  endtask

  initial begin
    logic [7:0] tmp_val;
    int k, rel;
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; p_we[i] = 0; p_addr[i] = 0; p_wdata[i] = 0;
    end
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    drive_cycle(1'b1);

    // Single write from requester 0, grant one cycle after sampling
    g_cyc.delete(); g_id.delete();
    rel = cyc + 1;
    do_txn(0, 1, 2'd1, 8'h02);
    check_eq("w_first_gnt_cyc", (g_cyc.size() > 0) ? g_cyc[0] : -1, rel + 1);

    // Fill the file, then read back address 3 through requester 1
    do_txn(0, 1, 2'd0, 8'h00);
    do_txn(0, 1, 2'd1, 8'h02);
    do_txn(0, 1, 2'd2, 8'h01);
    do_txn(0, 1, 2'd3, 8'h11);
    tmp_val = rdata0;
    do_txn(1, 0, 2'd3, 8'h00);
    check_eq("rd3_rdata1", rdata1, 8'h11);
    check_eq("rd3_rdata0_hold", rdata0, tmp_val);

    // Both held high from reset: alternating grants every 3 cycles
    drive_cycle(1'b1);
    g_cyc.delete(); g_id.delete();
    auto_repost = 1;
    post(0, 0, 2'd0, 8'h00);
    post(1, 0, 2'd1, 8'h00);
    repeat (13) drive_cycle(1'b0);
    pend[0] = 0; pend[1] = 0; auto_repost = 0;
    repeat (3) drive_cycle(1'b0);
    check_eq("rr_count_ge4", g_id.size() >= 4, 1);
    if (g_id.size() >= 4) begin
      for (int j = 0; j < 4; j++) check_eq("rr_order", g_id[j], j % 2);
      for (int j = 0; j < 3; j++) check_eq("rr_spacing", g_cyc[j + 1] - g_cyc[j], 3);
    end

    // Reset during the ACCESS cycle of a write aborts it
    do_txn(0, 1, 2'd2, 8'h5A);
    post(0, 1, 2'd2, 8'hEE);
    k = 0;
    while (k < 20 && !(acc_valid && acc_t == cyc + 1)) begin
      drive_cycle(1'b0);
      k++;
    end
    check_eq("abort_wait", k < 20, 1);
    pend[0] = 0;
    drive_cycle(1'b1);
    drive_cycle(1'b0);
    check_eq("abort_no_done", done0, 0);
    do_txn(1, 0, 2'd2, 8'h00);
    check_eq("abort_rdata1", rdata1, 8'h5A);

    // req1 alone, then both: req0 must win the tie
    drive_cycle(1'b1);
    g_cyc.delete(); g_id.delete();
    do_txn(1, 0, 2'd0, 8'h00);
    post(0, 0, 2'd1, 8'h00);
    post(1, 0, 2'd2, 8'h00);
    k = 0;
    while (k < 20 && (pend[0] || pend[1] || acc_valid)) begin
      drive_cycle(1'b0);
      k++;
    end
    check_eq("ptr_wait", k < 20, 1);
    check_eq("ptr_count", g_id.size(), 3);
    if (g_id.size() == 3) begin
      check_eq("ptr_first", g_id[0], 1);
      check_eq("ptr_tie_winner", g_id[1], 0);
      check_eq("ptr_second", g_id[2], 1);
    end

    // Random traffic with occasional resets
    rand_en = 1;
    for (int n = 0; n < 400; n++) drive_cycle($urandom_range(0, 49) == 0);
    rand_en = 0;
    pend[0] = 0; pend[1] = 0;
    repeat (4) drive_cycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 SHALL have exactly one clock and a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req0, req1  input  1 each  access request from requester 0 and requester 1.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; qualified by the matching req.
REQ-006 addr0, addr1  input  2 each  register index 0..3.
REQ-007 wdata0, wdata1  input  8 each  write data.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse; the access is executing this cycle.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse.
REQ-010 rdata0, rdata1  output  8 each  read result; valid when the matching done is high for a read, then held.
REQ-011 rf_addr  output  2  register-file address.
REQ-012 rf_rd, rf_wr  output  1 each  register-file read and write strobes.
REQ-013 rf_wdata  output  8  register-file write data.
REQ-014 rf_rdata  input  8  register-file read data, combinational from rf_addr/rf_rd.
REQ-015 busy  output  1  high in ACCESS and RESP.

Function
REQ-016 FSM SHALL have states IDLE, ACCESS and RESP; all outputs SHALL be registered or decoded from registered state only.
REQ-017 IDLE: req0 and req1 SHALL be sampled only in IDLE; if either is high, the winner's we/addr/wdata are latched and the next state is ACCESS; otherwise the FSM stays in IDLE.
REQ-018 Arbitration SHALL be round-robin using a 1-bit priority pointer: if both requesters are high, the pointed requester wins; if only one is high, that one wins regardless of the pointer.
REQ-019 On each grant the pointer SHALL move to the other requester (grant to 0 sets pointer = 1, and vice versa).
REQ-020 ACCESS (exactly 1 cycle): rf_addr = latched addr; rf_wr = we; rf_rd = !we; rf_wdata = latched wdata for a write, 0 for a read; gnt of the winner = 1.
REQ-021 ACCESS, read: rf_rdata SHALL be captured at the end of the ACCESS cycle into the winner's rdata register.
REQ-022 ACCESS, write: the winner's rdata register SHALL be unchanged.
REQ-023 RESP (exactly 1 cycle): done of the winner = 1; rf_rd = rf_wr = 0; the next state SHALL be IDLE.
REQ-024 Latency SHALL be 3 cycles from request acceptance: IDLE sample, then ACCESS, then RESP. Maximum throughput SHALL be one access per 3 cycles.
REQ-025 A requester SHALL keep req high until its gnt. If req is still high in the IDLE cycle after done, it SHALL be treated as a new request.
REQ-026 Outside ACCESS: rf_rd, rf_wr, rf_addr and rf_wdata SHALL be 0. gnt and done SHALL be one-hot or zero, never both requesters at once.
REQ-027 rdata of the non-winning requester SHALL never change.

Reset
REQ-028 When rst is high: state = IDLE, pointer = requester 0; all gnt, done, busy and rf_* outputs = 0; rdata0 = rdata1 = 8'h00.
REQ-029 Reset asserted in ACCESS or RESP SHALL abort the access: no done pulse, and no write issued in the following cycle.
REQ-030 The first request sampling after reset SHALL occur in the first cycle with rst low.

Verification
REQ-031 Req0 write addr=1 wdata=8'h02, req1 idle -> gnt0 in cycle 2 with rf_wr=1, rf_addr=1, rf_wdata=8'h02; done0 in cycle 3; busy high in cycles 2-3.
REQ-032 Prior writes of 00/02/01/11 to addresses 0-3, then req1 reads addr 3 -> rf_rd=1 with gnt1; done1 with rdata1=8'h11; rdata0 unchanged.
REQ-033 Req0 and req1 both held high after reset -> grants in order 0,1,0,1 with exactly 3 cycles between successive grants.
REQ-034 Rst asserted during the ACCESS cycle of a write -> no done pulse; next cycle all outputs 0 and state IDLE; a following read of the same address through the arbiter returns the pre-access value.
REQ-035 Req1 alone, then req0 and req1 together -> req0 wins because the pointer = 0 after the grant to 1.
